// File: rtl/mcash_cache_top_if.sv
// mcash request/return bundle for three channels.
// master = requester side, slave = line store side.
interface mcash_cache_top_if;
   logic         mcash_ch0_req_valid_i;
   logic         mcash_ch0_req_allowIn_o;
   logic [2:0]   mcash_ch0_req_op_i;
   logic [27:0]  mcash_ch0_req_addr_i;
   logic [127:0] mcash_ch0_req_data_i;
   logic         mcash_ch0_rtn_valid_o;
   logic         mcash_ch0_rtn_ready_i;
   logic [127:0] mcash_ch0_rtn_data_o;

   logic         mcash_ch1_req_valid_i;
   logic         mcash_ch1_req_allowIn_o;
   logic [2:0]   mcash_ch1_req_op_i;
   logic [27:0]  mcash_ch1_req_addr_i;
   logic [127:0] mcash_ch1_req_data_i;
   logic         mcash_ch1_rtn_valid_o;
   logic         mcash_ch1_rtn_ready_i;
   logic [127:0] mcash_ch1_rtn_data_o;

   logic         mcash_ch2_req_valid_i;
   logic         mcash_ch2_req_allowIn_o;
   logic [2:0]   mcash_ch2_req_op_i;
   logic [27:0]  mcash_ch2_req_addr_i;
   logic [127:0] mcash_ch2_req_data_i;
   logic         mcash_ch2_rtn_valid_o;
   logic         mcash_ch2_rtn_ready_i;
   logic [127:0] mcash_ch2_rtn_data_o;

   modport master (
      output mcash_ch0_req_valid_i, mcash_ch0_req_op_i,
      output mcash_ch0_req_addr_i, mcash_ch0_req_data_i,
      output mcash_ch0_rtn_ready_i,
      input  mcash_ch0_req_allowIn_o, mcash_ch0_rtn_valid_o,
      input  mcash_ch0_rtn_data_o,
      output mcash_ch1_req_valid_i, mcash_ch1_req_op_i,
      output mcash_ch1_req_addr_i, mcash_ch1_req_data_i,
      output mcash_ch1_rtn_ready_i,
      input  mcash_ch1_req_allowIn_o, mcash_ch1_rtn_valid_o,
      input  mcash_ch1_rtn_data_o,
      output mcash_ch2_req_valid_i, mcash_ch2_req_op_i,
      output mcash_ch2_req_addr_i, mcash_ch2_req_data_i,
      output mcash_ch2_rtn_ready_i,
      input  mcash_ch2_req_allowIn_o, mcash_ch2_rtn_valid_o,
      input  mcash_ch2_rtn_data_o
   );

   modport slave (
      input  mcash_ch0_req_valid_i, mcash_ch0_req_op_i,
      input  mcash_ch0_req_addr_i, mcash_ch0_req_data_i,
      input  mcash_ch0_rtn_ready_i,
      output mcash_ch0_req_allowIn_o, mcash_ch0_rtn_valid_o,
      output mcash_ch0_rtn_data_o,
      input  mcash_ch1_req_valid_i, mcash_ch1_req_op_i,
      input  mcash_ch1_req_addr_i, mcash_ch1_req_data_i,
      input  mcash_ch1_rtn_ready_i,
      output mcash_ch1_req_allowIn_o, mcash_ch1_rtn_valid_o,
      output mcash_ch1_rtn_data_o,
      input  mcash_ch2_req_valid_i, mcash_ch2_req_op_i,
      input  mcash_ch2_req_addr_i, mcash_ch2_req_data_i,
      input  mcash_ch2_rtn_ready_i,
      output mcash_ch2_req_allowIn_o, mcash_ch2_rtn_valid_o,
      output mcash_ch2_rtn_data_o
   );
endinterface

// File: rtl/mcash_cache_top.sv
// mcash shared 3-channel 128-bit line store with round-robin grant.
// Define MCASH_FIXED_PRIO_EN for fixed priority ch0 > ch1 > ch2.
module mcash_cache_top #(
   parameter int DEPTH = 16
) (
   input logic clk_i,
   input logic rst_i,
   mcash_cache_top_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [2:0]       vld;
   logic [2:0]       rdy;
   logic [2:0]       gnt;
   logic [2:0]       elig;
   logic [2:0]       need_rtn;
   logic [2:0]       rtn_vld;
   logic [2:0]       op   [3];
   logic [IDX_W-1:0] idx  [3];
   logic [127:0]     wdat [3];
   logic [127:0]     rdat [3];
   logic [127:0]     mem  [DEPTH];

   logic [2:0]       w_op;
   logic [IDX_W-1:0] w_idx;
   logic [127:0]     w_data;
   logic             w_wr;

   assign vld = {bus.mcash_ch2_req_valid_i,
                 bus.mcash_ch1_req_valid_i,
                 bus.mcash_ch0_req_valid_i};
   assign rdy = {bus.mcash_ch2_rtn_ready_i,
                 bus.mcash_ch1_rtn_ready_i,
                 bus.mcash_ch0_rtn_ready_i};

   assign op[0]   = bus.mcash_ch0_req_op_i;
   assign op[1]   = bus.mcash_ch1_req_op_i;
   assign op[2]   = bus.mcash_ch2_req_op_i;
   assign idx[0]  = bus.mcash_ch0_req_addr_i[IDX_W-1:0];
   assign idx[1]  = bus.mcash_ch1_req_addr_i[IDX_W-1:0];
   assign idx[2]  = bus.mcash_ch2_req_addr_i[IDX_W-1:0];
   assign wdat[0] = bus.mcash_ch0_req_data_i;
   assign wdat[1] = bus.mcash_ch1_req_data_i;
   assign wdat[2] = bus.mcash_ch2_req_data_i;

   always_comb begin
      need_rtn = '0;
      for (int n = 0; n < 3; n++)
         need_rtn[n] = (op[n] == 3'b001) || (op[n] == 3'b011);
   end

   // A held, unconsumed return only blocks ops that produce a return.
   assign elig = vld & (~need_rtn | ~rtn_vld | rdy);

`ifdef MCASH_FIXED_PRIO_EN
   always_comb begin
      gnt = 3'b000;
      if (elig[0])      gnt = 3'b001;
      else if (elig[1]) gnt = 3'b010;
      else if (elig[2]) gnt = 3'b100;
   end
`else
   logic [1:0] ptr;

   always_comb begin
      gnt = 3'b000;
      case (ptr)
         2'd1: begin
            if (elig[1])      gnt = 3'b010;
            else if (elig[2]) gnt = 3'b100;
            else if (elig[0]) gnt = 3'b001;
         end
         2'd2: begin
            if (elig[2])      gnt = 3'b100;
            else if (elig[0]) gnt = 3'b001;
            else if (elig[1]) gnt = 3'b010;
         end
         default: begin
            if (elig[0])      gnt = 3'b001;
            else if (elig[1]) gnt = 3'b010;
            else if (elig[2]) gnt = 3'b100;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)      ptr <= 2'd0;
      else if (gnt[0]) ptr <= 2'd1;
      else if (gnt[1]) ptr <= 2'd2;
      else if (gnt[2]) ptr <= 2'd0;
   end
`endif

   assign bus.mcash_ch0_req_allowIn_o = gnt[0];
   assign bus.mcash_ch1_req_allowIn_o = gnt[1];
   assign bus.mcash_ch2_req_allowIn_o = gnt[2];

   always_comb begin
      w_op   = 3'b000;
      w_idx  = '0;
      w_data = '0;
      for (int n = 0; n < 3; n++) begin
         if (gnt[n]) begin
            w_op   = op[n];
            w_idx  = idx[n];
            w_data = wdat[n];
         end
      end
   end

   assign w_wr = (w_op == 3'b010) || (w_op == 3'b011);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (w_wr) begin
         mem[w_idx] <= w_data;
      end
   end

   // Return read sees the pre-edge line, so SWAP returns old data.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rtn_vld <= '0;
         for (int n = 0; n < 3; n++)
            rdat[n] <= '0;
      end else begin
         for (int n = 0; n < 3; n++) begin
            if (gnt[n] && need_rtn[n]) begin
               rtn_vld[n] <= 1'b1;
               rdat[n]    <= mem[idx[n]];
            end else if (rdy[n]) begin
               rtn_vld[n] <= 1'b0;
            end
         end
      end
   end

   assign bus.mcash_ch0_rtn_valid_o = rtn_vld[0];
   assign bus.mcash_ch1_rtn_valid_o = rtn_vld[1];
   assign bus.mcash_ch2_rtn_valid_o = rtn_vld[2];
   assign bus.mcash_ch0_rtn_data_o  = rdat[0];
   assign bus.mcash_ch1_rtn_data_o  = rdat[1];
   assign bus.mcash_ch2_rtn_data_o  = rdat[2];
endmodule

// File: tb/tb_mcash_cache_top.sv
// Directed bench for mcash_cache_top (default round-robin build).
// Inputs change on the falling edge; outputs are sampled there too.
module tb_mcash_cache_top;
   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_RD  = 3'b001;
   localparam logic [2:0] OP_WR  = 3'b010;
   localparam logic [2:0] OP_SW  = 3'b011;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [2:0]   allow;
   logic [2:0]   rvld;
   logic [127:0] d1;
   logic [2:0]   e;

   always #5 clk = ~clk;

   mcash_cache_top_if bus ();

   mcash_cache_top dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   assign allow = {bus.mcash_ch2_req_allowIn_o,
                   bus.mcash_ch1_req_allowIn_o,
                   bus.mcash_ch0_req_allowIn_o};
   assign rvld  = {bus.mcash_ch2_rtn_valid_o,
                   bus.mcash_ch1_rtn_valid_o,
                   bus.mcash_ch0_rtn_valid_o};

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.mcash_ch0_req_valid_i = 1'b0;
      bus.mcash_ch0_req_op_i    = OP_NOP;
      bus.mcash_ch0_req_addr_i  = '0;
      bus.mcash_ch0_req_data_i  = '0;
      bus.mcash_ch1_req_valid_i = 1'b0;
      bus.mcash_ch1_req_op_i    = OP_NOP;
      bus.mcash_ch1_req_addr_i  = '0;
      bus.mcash_ch1_req_data_i  = '0;
      bus.mcash_ch2_req_valid_i = 1'b0;
      bus.mcash_ch2_req_op_i    = OP_NOP;
      bus.mcash_ch2_req_addr_i  = '0;
      bus.mcash_ch2_req_data_i  = '0;
   endtask

   task automatic drv(input int n, input logic [2:0] op,
                      input logic [27:0] a, input logic [127:0] d);
      case (n)
         0: begin
            bus.mcash_ch0_req_valid_i = 1'b1;
            bus.mcash_ch0_req_op_i    = op;
            bus.mcash_ch0_req_addr_i  = a;
            bus.mcash_ch0_req_data_i  = d;
         end
         1: begin
            bus.mcash_ch1_req_valid_i = 1'b1;
            bus.mcash_ch1_req_op_i    = op;
            bus.mcash_ch1_req_addr_i  = a;
            bus.mcash_ch1_req_data_i  = d;
         end
         default: begin
            bus.mcash_ch2_req_valid_i = 1'b1;
            bus.mcash_ch2_req_op_i    = op;
            bus.mcash_ch2_req_addr_i  = a;
            bus.mcash_ch2_req_data_i  = d;
         end
      endcase
   endtask

   task automatic set_rdy(input logic [2:0] r);
      bus.mcash_ch0_rtn_ready_i = r[0];
      bus.mcash_ch1_rtn_ready_i = r[1];
      bus.mcash_ch2_rtn_ready_i = r[2];
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      idle();
      set_rdy(3'b111);
      #2;
      chk("rst_rtn_valid", {125'd0, rvld}, 128'd0);
      chk("rst_rtn_data0", bus.mcash_ch0_rtn_data_o, 128'd0);
      chk("rst_allow", {125'd0, allow}, 128'd0);
      @(negedge clk);
      rst = 1'b1;

      // read of a cleared line
      drv(0, OP_RD, 28'h2, '0);
      #1 chk("t1_allow", {125'd0, allow}, 128'd1);
      tick();
      chk("t1_rvld0", {127'd0, bus.mcash_ch0_rtn_valid_o}, 128'd1);
      chk("t1_rdat0", bus.mcash_ch0_rtn_data_o, 128'd0);
      idle();
      tick();
      chk("t1_drop0", {127'd0, bus.mcash_ch0_rtn_valid_o}, 128'd0);

      // write then read back, aliasing index via ch1
      drv(0, OP_WR, 28'h2, {16{8'hA5}});
      #1 chk("t2_wr_allow", {125'd0, allow}, 128'd1);
      tick();
      drv(0, OP_RD, 28'h2, '0);
      #1;
      tick();
      chk("t2_rdat0", bus.mcash_ch0_rtn_data_o, {16{8'hA5}});
      chk("t2_rvld0", {127'd0, bus.mcash_ch0_rtn_valid_o}, 128'd1);
      idle();
      drv(1, OP_RD, 28'h12, '0);
      #1 chk("t2_allow1", {125'd0, allow}, 128'd2);
      tick();
      chk("t2_rdat1", bus.mcash_ch1_rtn_data_o, {16{8'hA5}});
      idle();

      // NOP is eligible while a return is held
      drv(0, OP_RD, 28'h2, '0);
      #1;
      tick();
      idle();
      set_rdy(3'b110);
      drv(0, 3'b100, 28'h2, '0);
      #1 chk("nop_allow", {125'd0, allow}, 128'd1);
      tick();
      chk("nop_hold_v", {127'd0, bus.mcash_ch0_rtn_valid_o}, 128'd1);
      chk("nop_hold_d", bus.mcash_ch0_rtn_data_o, {16{8'hA5}});
      drv(0, OP_RD, 28'h2, '0);
      #1 chk("held_rd_block", {125'd0, allow}, 128'd0);
      set_rdy(3'b111);
      #1 chk("rdy_rd_allow", {125'd0, allow}, 128'd1);
      idle();
      tick();

      // round-robin from a fresh pointer
      rst = 1'b0;
      #1 rst = 1'b1;
      drv(0, OP_RD, 28'h0, '0);
      drv(1, OP_RD, 28'h0, '0);
      drv(2, OP_RD, 28'h0, '0);
      for (int i = 0; i < 6; i++) begin
         e = 3'b001 << (i % 3);
         #1 chk($sformatf("rr_allow_%0d", i), {125'd0, allow}, {125'd0, e});
         tick();
      end
      idle();

      // backpressure on ch1 with nonzero held data
      d1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      drv(0, OP_WR, 28'h3, d1);
      #1;
      tick();
      idle();
      drv(1, OP_RD, 28'h3, '0);
      #1 chk("bp_rd1_allow", {125'd0, allow}, 128'd2);
      tick();
      idle();
      set_rdy(3'b101);
      chk("bp_rdat1", bus.mcash_ch1_rtn_data_o, d1);
      drv(0, OP_RD, 28'h0, '0);
      drv(1, OP_RD, 28'h3, '0);
      drv(2, OP_RD, 28'h0, '0);
      for (int i = 0; i < 4; i++) begin
         e = (i % 2 == 0) ? 3'b100 : 3'b001;
         #1 chk($sformatf("bp_allow_%0d", i), {125'd0, allow}, {125'd0, e});
         tick();
         chk($sformatf("bp_hold_v_%0d", i),
             {127'd0, bus.mcash_ch1_rtn_valid_o}, 128'd1);
         chk($sformatf("bp_hold_d_%0d", i), bus.mcash_ch1_rtn_data_o, d1);
      end
      idle();
      set_rdy(3'b111);
      tick();
      chk("bp_release", {127'd0, bus.mcash_ch1_rtn_valid_o}, 128'd0);

      // swap returns old line, writes new
      drv(2, OP_WR, 28'h5, 128'h7);
      #1;
      tick();
      idle();
      drv(2, OP_SW, 28'h5, 128'h1);
      #1 chk("sw_allow", {125'd0, allow}, 128'd4);
      tick();
      chk("sw_old", bus.mcash_ch2_rtn_data_o, 128'h7);
      idle();
      drv(2, OP_RD, 28'h5, '0);
      #1;
      tick();
      chk("sw_new", bus.mcash_ch2_rtn_data_o, 128'h1);
      idle();

      // async reset while a return is held
      drv(0, OP_RD, 28'h5, '0);
      #1;
      tick();
      idle();
      set_rdy(3'b110);
      chk("ar_pre_v", {127'd0, bus.mcash_ch0_rtn_valid_o}, 128'd1);
      chk("ar_pre_d", bus.mcash_ch0_rtn_data_o, 128'h1);
      #2 rst = 1'b0;
      #1 chk("ar_v", {127'd0, bus.mcash_ch0_rtn_valid_o}, 128'd0);
      chk("ar_d", bus.mcash_ch0_rtn_data_o, 128'd0);
      #1 rst = 1'b1;
      @(negedge clk);
      set_rdy(3'b111);
      drv(0, OP_RD, 28'h5, '0);
      #1;
      tick();
      chk("ar_rd_v", {127'd0, bus.mcash_ch0_rtn_valid_o}, 128'd1);
      chk("ar_rd_d", bus.mcash_ch0_rtn_data_o, 128'd0);
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
